push_event_arbiter: RTL and testbench
=====================================

PUSH_EVENT_ARBITER -- requirements
Module: push_event_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the output event queue depth (power of two, at least 2).
REQ-002 The block SHALL have parameter TS_W, default 16, meaning the timestamp counter width in bits.
REQ-003 The block SHALL have port i_Clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port i_Rst, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port i_Push, input, 4 bits: per-lane single-cycle press pulses from the push controller.
REQ-006 The block SHALL have port o_Valid, output, 1 bit: the queue head is valid.
REQ-007 The block SHALL have port i_Ready, input, 1 bit: the consumer accepts the head.
REQ-008 The block SHALL have port o_Lane, output, 2 bits: lane index of the head event.
REQ-009 The block SHALL have port o_Time, output, TS_W bits: capture timestamp of the head event (present only with PUSH_TIMESTAMP_EN).
REQ-010 The block SHALL have port o_Count, output, clog2(FIFO_DEPTH)+1 bits: queue occupancy.
REQ-011 The block SHALL have port o_Overrun, output, 1 bit: sticky flag indicating a press was lost.

Function
REQ-012 Each lane SHALL have a pending bit that is set at the edge where i_Push[k]=1 is sampled.
REQ-013 A pending bit SHALL be cleared at the edge where that lane is granted, unless i_Push[k]=1 in the same cycle, in which case it SHALL stay set as a new event.
REQ-014 In each cycle where the queue is not full (o_Count < FIFO_DEPTH, evaluated before that cycle's pop) and any pending bit is set, exactly one lane SHALL be granted and written into the queue at that edge.
REQ-015 Grant selection SHALL be round-robin: search starts at the lane after the last granted lane (last_grant+1 mod 4), and the pointer SHALL update only on a grant.
REQ-016 A press whose pulse is sampled at edge t with an empty queue and no other pending lanes SHALL produce o_Valid=1 after edge t+1, i.e. two-cycle latency from pulse to valid.
REQ-017 A pop SHALL occur at an edge where o_Valid=1 and i_Ready=1; o_Lane and o_Time SHALL hold stable while o_Valid=1 and i_Ready=0.
REQ-018 A simultaneous write and pop SHALL leave o_Count unchanged; a pop while full SHALL NOT enable a write in the same cycle.
REQ-019 o_Valid SHALL equal (o_Count != 0); i_Ready while empty SHALL have no effect.
REQ-020 If i_Push[k]=1 while lane k is pending and not granted that cycle, the event SHALL be merged (one queue entry) and o_Overrun SHALL set.
REQ-021 o_Overrun SHALL clear only on reset.
REQ-022 Queue pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-023 When i_Rst=0 at a rising edge, the block SHALL clear all pending bits, the queue, and o_Overrun.
REQ-024 Reset SHALL set o_Count=0, o_Valid=0, o_Lane=0, o_Time=0, the timestamp counter to 0, and the round-robin pointer so that lane 0 is searched first.
REQ-025 Reset asserted mid-operation SHALL discard queued and pending events without emitting them, and i_Push SHALL be ignored during that cycle.

Configuration
REQ-026 When macro PUSH_TIMESTAMP_EN is defined, a free-running TS_W-bit counter SHALL increment every cycle and wrap at 2^TS_W-1 to 0.
REQ-027 With PUSH_TIMESTAMP_EN defined, each lane SHALL latch the counter value at its pulse-sampling edge (refreshed on a merged re-press), and that value SHALL travel with the event to o_Time.
REQ-028 Without PUSH_TIMESTAMP_EN, the counter, per-lane timestamp registers and the o_Time port SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Bench SHALL cover: reset, then i_Push=4'b0100 for 1 cycle with i_Ready=1 -> o_Valid=1 for exactly one cycle, two edges after the pulse, with o_Lane=2.
REQ-030 Bench SHALL cover: i_Push=4'b1111 in one cycle with i_Ready=1 -> lanes emitted in order 0,1,2,3 on consecutive cycles; a second 4'b1111 -> order 0,1,2,3 again.
REQ-031 Bench SHALL cover: i_Ready=0 with 5 single-lane presses (FIFO_DEPTH=4) -> o_Count saturates at 4, one lane stays pending, o_Overrun=0; raising i_Ready drains all 5 events.
REQ-032 Bench SHALL cover: lane 1 pressed twice while blocked by a full queue -> o_Overrun=1 and only one lane-1 event is emitted.
REQ-033 Bench SHALL cover: with PUSH_TIMESTAMP_EN and TS_W=4, a press sampled at counter value 15 followed by a press at 0 -> o_Time values 15 then 0.
REQ-034 Bench SHALL cover: i_Rst=0 with 3 entries queued -> o_Valid=0 and o_Count=0 after the edge, with no entry emitted.

Source files
------------

// File: rtl/push_event_arbiter.sv
// -----------------------------------------------------------------------------
// push_event_arbiter
//
// Collects single-cycle press pulses from four push lanes. Each press is held
// in a per-lane pending bit. One pending lane per cycle is picked round-robin
// and written into a small output event queue, which the consumer drains with
// a valid/ready handshake. If a lane is pressed again while its earlier press
// is still pending, the two presses merge into one event and a sticky overrun
// flag is set.
//
// Optional feature (compile-time macro PUSH_TIMESTAMP_EN):
//   A free-running TS_W-bit counter is added. Each lane latches the counter
//   value on its press. That value travels with the event and appears on o_Time.
//   When the macro is undefined, the counter, the per-lane timestamps and
//   o_Time are not built.
//
// Parameters
//   FIFO_DEPTH  event queue depth (power of two, >= 2)
//   TS_W        timestamp counter width
//
// Ports
//   i_Clk      clock, rising edge
//   i_Rst      synchronous reset, active low
//   i_Push     per-lane press pulses (4 lanes)
//   o_Valid    queue head valid (o_Count != 0)
//   i_Ready    consumer accepts the head this cycle
//   o_Lane     lane index of the head event
//   o_Time     capture timestamp of the head event (PUSH_TIMESTAMP_EN only)
//   o_Count    queue occupancy
//   o_Overrun  sticky: a press was merged into a still-pending one
// -----------------------------------------------------------------------------
module push_event_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W       = 16
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic [3:0]                    i_Push,
  output logic                          o_Valid,
  input  logic                          i_Ready,
  output logic [1:0]                    o_Lane,
`ifdef PUSH_TIMESTAMP_EN
  output logic [TS_W-1:0]               o_Time,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   o_Count,
  output logic                          o_Overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    pending;
  logic [1:0]    last_grant;
  logic          overrun;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    lane_mem [FIFO_DEPTH];

  logic          full;
  logic          found;
  logic          grant_en;
  logic [1:0]    grant_lane;
  logic [3:0]    grant_vec;
  logic          pop;

  // Round-robin pick: start at the lane after the last grant. At i == 4 the
  // index wraps back to last_grant itself, which is checked last.
  always_comb begin
    logic [1:0] idx;
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    idx        = '0;
    found      = 1'b0;
    grant_lane = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_grant + 2'(i);
      if (!found && pending[idx]) begin
        grant_lane = idx;
        found      = 1'b1;
      end
    end
  end

  // Fullness is judged on the occupancy before this cycle's pop. A pop while
  // full therefore never makes room for a write in the same cycle.
  assign full      = (count == CW'(FIFO_DEPTH));
  assign grant_en  = found && !full;
  assign grant_vec = grant_en ? (4'b0001 << grant_lane) : 4'b0000;
  assign pop       = (count != '0) && i_Ready;

  // NOTE: all state uses non-blocking assignments. Every register then samples
  // the pre-edge values, whatever order the statements are written in.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      pending    <= '0;
      last_grant <= 2'd3;            // lane 0 is searched first
      overrun    <= 1'b0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      // A re-press on the lane being granted starts a fresh event.
      pending <= i_Push | (pending & ~grant_vec);
      if (|(i_Push & pending & ~grant_vec))
        overrun <= 1'b1;
      if (grant_en) begin
        last_grant <= grant_lane;
        wr_ptr     <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(grant_en) - CW'(pop);
    end
  end

  // NOTE: queue storage has no reset. Only the pointers and the count define
  // which entries are live, and the head outputs are forced to zero while the
  // queue is empty.
  always_ff @(posedge i_Clk) begin
    if (i_Rst && grant_en)
      lane_mem[wr_ptr] <= grant_lane;
  end

  assign o_Valid   = (count != '0);
  assign o_Count   = count;
  assign o_Overrun = overrun;
  assign o_Lane    = o_Valid ? lane_mem[rd_ptr] : 2'd0;

`ifdef PUSH_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] lane_ts  [4];
  logic [TS_W-1:0] time_mem [FIFO_DEPTH];

  // Free-running counter that wraps naturally. Each lane captures the counter
  // value seen on its press edge. A merged re-press refreshes that capture.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      ts <= '0;
      for (int k = 0; k < 4; k++)
        lane_ts[k] <= '0;
    end else begin
      ts <= ts + 1'b1;
      for (int k = 0; k < 4; k++)
        if (i_Push[k])
          lane_ts[k] <= ts;
    end
  end

  // The granted event carries the timestamp held before this edge. A press on
  // the same lane at the same edge only updates the lane's capture register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst && grant_en)
      time_mem[wr_ptr] <= lane_ts[grant_lane];
  end

  assign o_Time = o_Valid ? time_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_push_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_push_event_arbiter
//
// Self-checking bench for push_event_arbiter.
// - A per-cycle vector table exercises reset, a single press, and two
//   all-lane bursts.
// - Hand-written sequences cover queue saturation, overrun merging, reset with
//   events still queued and, under PUSH_TIMESTAMP_EN, timestamp wrap.
// - A scoreboard queue holds the expected events. Each pop is compared against
//   it.
// -----------------------------------------------------------------------------
module tb_push_event_arbiter;

  localparam int TB_DEPTH = 4;
  localparam int TB_TS_W  = 4;

  logic       i_Clk;
  logic       i_Rst;
  logic [3:0] i_Push;
  logic       o_Valid;
  logic       i_Ready;
  logic [1:0] o_Lane;
  logic [2:0] o_Count;
  logic       o_Overrun;
`ifdef PUSH_TIMESTAMP_EN
  logic [TB_TS_W-1:0] o_Time;
`endif

  push_event_arbiter #(
    .FIFO_DEPTH(TB_DEPTH),
    .TS_W      (TB_TS_W)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Push   (i_Push),
    .o_Valid  (o_Valid),
    .i_Ready  (i_Ready),
    .o_Lane   (o_Lane),
`ifdef PUSH_TIMESTAMP_EN
    .o_Time   (o_Time),
`endif
    .o_Count  (o_Count),
    .o_Overrun(o_Overrun)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected)
      checks_passed++;
    else
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Scoreboard of expected events, in emission order.
  typedef struct {
    logic [1:0]         lane;
    logic [TB_TS_W-1:0] ts;
    logic               chk_time;
  } event_t;

  event_t sb[$];

  function automatic void expect_event(input logic [1:0] lane,
                                       input logic [TB_TS_W-1:0] ts,
                                       input logic chk_time);
    event_t e;
    e.lane     = lane;
    e.ts       = ts;
    e.chk_time = chk_time;
    sb.push_back(e);
  endfunction

  // Inputs change 1 ns after the rising edge. The monitor samples on the
  // falling edge, when both the inputs and the outputs are stable.
  always @(negedge i_Clk) begin
    if (i_Rst && o_Valid && i_Ready) begin
      if (sb.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        event_t e;
        e = sb.pop_front();
        check("sb_lane", int'(o_Lane), int'(e.lane));
`ifdef PUSH_TIMESTAMP_EN
        if (e.chk_time)
          check("sb_time", int'(o_Time), int'(e.ts));
`endif
      end
    end
  end

`ifdef PUSH_TIMESTAMP_EN
  // Reference timestamp: cleared by reset, otherwise counts every edge.
  logic [TB_TS_W-1:0] tb_ts;
  always @(posedge i_Clk)
    tb_ts <= i_Rst ? tb_ts + 1'b1 : '0;
`endif

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic do_reset();
    i_Rst  = 1'b0;
    i_Push = 4'b0000;
    sb.delete();
    tick();
    i_Rst  = 1'b1;
  endtask

  task automatic press(input int lane);
    i_Push = 4'b0001 << lane;
    expect_event(2'(lane), '0, 1'b0);
    tick();
    i_Push = 4'b0000;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || o_Count != 3'd0) && n < budget) begin
      tick();
      n++;
    end
    check(name, int'(sb.size() == 0 && o_Count == 3'd0), 1);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] push;
    logic       ready;
    logic       exp_valid;
    logic [1:0] exp_lane;
    int         exp_count;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  initial begin
    // Per-cycle vectors. The expected outputs are the values seen after the
    // edge that samples the inputs.
    vecs[0]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 0};  // reset state
    vecs[1]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, 0};  // lane 2 pulse
    vecs[2]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 1};  // valid two edges later
    vecs[3]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 0};  // only one cycle
    vecs[4]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 0};  // reset rr pointer
    vecs[5]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 0};  // all lanes
    vecs[6]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 1};
    vecs[7]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 1};
    vecs[8]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 1};
    vecs[9]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 1};
    vecs[10] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 0};
    vecs[11] = '{1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 0};  // second burst
    vecs[12] = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 1};
    vecs[13] = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 1};
    vecs[14] = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 1};
    vecs[15] = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 1};
    vecs[16] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 0};

    i_Rst   = 1'b0;
    i_Push  = 4'b0000;
    i_Ready = 1'b0;
    tick();
    tick();

    // ---- Table-driven section ----
    for (int i = 0; i < NVEC; i++) begin
      i_Rst   = vecs[i].rst;
      i_Push  = vecs[i].push;
      i_Ready = vecs[i].ready;
      if (!vecs[i].rst) begin
        sb.delete();
      end else begin
        for (int k = 0; k < 4; k++)
          if (vecs[i].push[k])
            expect_event(2'(k), '0, 1'b0);
      end
      tick();
      check($sformatf("vec%0d_valid", i), int'(o_Valid), int'(vecs[i].exp_valid));
      check($sformatf("vec%0d_lane", i), int'(o_Lane), int'(vecs[i].exp_lane));
      check($sformatf("vec%0d_count", i), int'(o_Count), vecs[i].exp_count);
    end
    i_Rst  = 1'b1;
    i_Push = 4'b0000;

    // ---- Saturation: five presses against a stalled consumer ----
    do_reset();
    i_Ready = 1'b0;
    press(0);
    press(1);
    press(2);
    press(3);
    press(0);
    tick();
    tick();
    check("sat_count", int'(o_Count), 4);
    check("sat_valid", int'(o_Valid), 1);
    check("sat_head_lane", int'(o_Lane), 0);
    check("sat_overrun", int'(o_Overrun), 0);
    tick();
    tick();
    check("sat_hold_lane", int'(o_Lane), 0);
    check("sat_hold_count", int'(o_Count), 4);
    i_Ready = 1'b1;
    wait_drain("sat_drain", 20);
    check("sat_overrun_after", int'(o_Overrun), 0);

    // ---- Overrun: lane 1 pressed twice while the queue is full ----
    do_reset();
    i_Ready = 1'b0;
    press(0);
    press(2);
    press(3);
    press(0);
    tick();
    tick();
    check("ovr_full", int'(o_Count), 4);
    press(1);
    tick();
    check("ovr_first_press", int'(o_Overrun), 0);
    i_Push = 4'b0010;              // merged re-press, no new event expected
    tick();
    i_Push = 4'b0000;
    check("ovr_set", int'(o_Overrun), 1);
    i_Ready = 1'b1;
    wait_drain("ovr_drain", 20);
    check("ovr_sticky", int'(o_Overrun), 1);

    // ---- Reset with three entries queued ----
    do_reset();
    check("rst_clears_overrun", int'(o_Overrun), 0);
    i_Ready = 1'b0;
    i_Push  = 4'b0111;
    tick();
    i_Push  = 4'b0000;
    begin
      int n;
      n = 0;
      while (o_Count != 3'd3 && n < 10) begin
        tick();
        n++;
      end
    end
    check("mid_count3", int'(o_Count), 3);
    i_Rst   = 1'b0;
    i_Push  = 4'b1000;             // ignored during reset
    i_Ready = 1'b1;
    sb.delete();
    tick();
    check("mid_rst_valid", int'(o_Valid), 0);
    check("mid_rst_count", int'(o_Count), 0);
    check("mid_rst_lane", int'(o_Lane), 0);
    i_Rst  = 1'b1;
    i_Push = 4'b0000;
    repeat (6) tick();
    check("mid_after_valid", int'(o_Valid), 0);
    check("mid_after_count", int'(o_Count), 0);

`ifdef PUSH_TIMESTAMP_EN
    // ---- Timestamp wrap: presses sampled at counter 15 and then 0 ----
    do_reset();
    i_Ready = 1'b1;
    begin
      int n;
      n = 0;
      while (tb_ts != 4'd15 && n < 40) begin
        tick();
        n++;
      end
    end
    check("ts_reach_15", int'(tb_ts), 15);
    i_Push = 4'b0010;
    expect_event(2'd1, 4'd15, 1'b1);
    tick();
    i_Push = 4'b0100;
    expect_event(2'd2, 4'd0, 1'b1);
    tick();
    i_Push = 4'b0000;
    wait_drain("ts_drain", 20);
`endif

    tick();
    check("sb_empty_end", sb.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
